// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus constants and the sprite-DMA state type.
package nes_bus_pkg;

    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;
    localparam int unsigned OAM_XFER_BYTES = 256;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma_controller.sv
// Sprite DMA engine: halts the CPU and copies one 256-byte page into PPU OAM,
// arbitrating the cpu_memory port between the CPU and the engine.
module oam_dma_controller
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = ADDR_OAMDMA,
    parameter int unsigned XFER_BYTES   = OAM_XFER_BYTES
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_w,
    input  logic        cpu_r,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_data,
    output logic        mem_w,
    output logic        mem_r,
    input  logic [7:0]  mem_out,
    output logic        cpu_rdy,
    output logic        oam_w,
    output logic [7:0]  oam_data,
    output logic        dma_active
);

    localparam logic [7:0] LAST_COUNT = 8'(XFER_BYTES - 1);

    dma_state_t state;
    logic [7:0] count;
    logic [7:0] page;
    logic       odd;

    // oam_data doubles as the read buffer; oam_w is set on the READ->WRITE edge,
    // so it is high exactly while the state register holds WRITE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= DMA_IDLE;
            count    <= 8'h00;
            page     <= 8'h00;
            odd      <= 1'b0;
            oam_w    <= 1'b0;
            oam_data <= 8'h00;
        end else begin
            odd   <= ~odd;
            oam_w <= 1'b0;
            case (state)
                DMA_IDLE: begin
                    if (cpu_w && cpu_address == DMA_REG_ADDR) begin
                        page  <= cpu_data;
                        state <= DMA_HALT;
                    end
                end
                DMA_HALT:  state <= odd ? DMA_ALIGN : DMA_READ;
                DMA_ALIGN: state <= DMA_READ;
                DMA_READ: begin
                    oam_data <= mem_out;
                    oam_w    <= 1'b1;
                    state    <= DMA_WRITE;
                end
                DMA_WRITE: begin
                    if (count == LAST_COUNT) begin
                        count <= 8'h00;
                        state <= DMA_IDLE;
                    end else begin
                        count <= count + 8'h01;
                        state <= DMA_READ;
                    end
                end
                default: state <= DMA_IDLE;
            endcase
        end
    end

    assign cpu_rdy    = (state == DMA_IDLE);
    assign dma_active = ~cpu_rdy;

    // While the engine owns the port, CPU strobes are dropped, not forwarded.
    always_comb begin
        mem_address = cpu_address;
        mem_data    = cpu_data;
        mem_w       = cpu_w;
        mem_r       = cpu_r;
        if (state != DMA_IDLE) begin
            mem_address = {page, count};
            mem_data    = 8'h00;
            mem_w       = 1'b0;
            mem_r       = (state == DMA_READ);
        end
    end

endmodule
